// File: rtl/ycsep_boxcar.sv
// Composite luma/chroma separator: a boxcar running average over one subcarrier
// period gives luma, and the centre tap minus that average gives chroma.
module ycsep_boxcar #(
    parameter int DATA_W = 12,
    parameter int WINDOW = 21,
    parameter int FRAC_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] data_in,
    input  logic                     clear,
    input  logic [1:0]               mode,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] luma_out,
    output logic signed [DATA_W-1:0] chroma_out,
    output logic                     primed
);

    localparam int ACC_W  = DATA_W + $clog2(WINDOW);
    localparam int CTR    = (WINDOW - 1) / 2;
    localparam int PROD_W = ACC_W + FRAC_W + 1;
    localparam int CNT_W  = $clog2(WINDOW + 1);

    localparam logic [CNT_W-1:0]         CNT_FULL = CNT_W'(WINDOW);
    localparam logic signed [PROD_W-1:0] RECIP    = PROD_W'((2 ** FRAC_W + WINDOW / 2) / WINDOW);
    localparam logic signed [PROD_W-1:0] HALF     = PROD_W'(2 ** (FRAC_W - 1));
    localparam logic signed [DATA_W-1:0] D_MAX    = {1'b0, {(DATA_W - 1){1'b1}}};
    localparam logic signed [DATA_W-1:0] D_MIN    = {1'b1, {(DATA_W - 1){1'b0}}};

    typedef enum logic [1:0] {
        MODE_SEP  = 2'd0,
        MODE_BYP  = 2'd1,
        MODE_LUMA = 2'd2
    } mode_e;

    function automatic logic signed [DATA_W-1:0] sat_luma(input logic signed [PROD_W-1:0] v);
        if (v > PROD_W'(D_MAX)) begin
            sat_luma = D_MAX;
        end else if (v < PROD_W'(D_MIN)) begin
            sat_luma = D_MIN;
        end else begin
            sat_luma = v[DATA_W-1:0];
        end
    endfunction

    function automatic logic signed [DATA_W-1:0] sat_chroma(input logic signed [DATA_W:0] v);
        if (v[DATA_W] != v[DATA_W-1]) begin
            sat_chroma = v[DATA_W] ? D_MIN : D_MAX;
        end else begin
            sat_chroma = v[DATA_W-1:0];
        end
    endfunction

    logic signed [DATA_W-1:0] r_taps [WINDOW];
    logic signed [ACC_W-1:0]  r_acc;
    logic [CNT_W-1:0]         r_count;
    logic                     r_primed;
    logic                     r_s1_valid;
    logic signed [DATA_W-1:0] r_s1_ctr;
    logic signed [DATA_W-1:0] r_s1_raw;
    mode_e                    r_s1_mode;
    logic                     r_out_valid;
    logic signed [DATA_W-1:0] r_luma;
    logic signed [DATA_W-1:0] r_chroma;

    mode_e                    w_mode;
    logic [CNT_W-1:0]         w_count_next;
    logic signed [ACC_W-1:0]  w_acc_next;
    logic                     w_s1_valid;
    logic signed [PROD_W-1:0] w_round;
    logic signed [PROD_W-1:0] w_luma_wide;
    logic signed [DATA_W-1:0] w_luma_sat;
    logic signed [DATA_W:0]   w_chroma_wide;
    logic signed [DATA_W-1:0] w_chroma_sat;
    logic signed [DATA_W-1:0] w_luma_sel;
    logic signed [DATA_W-1:0] w_chroma_sel;

    // Mode decode; the reserved encoding behaves as SEPARATE.
    always_comb begin
        w_mode = MODE_SEP;
        case (mode)
            2'd1:    w_mode = MODE_BYP;
            2'd2:    w_mode = MODE_LUMA;
            default: w_mode = MODE_SEP;
        endcase
    end

    // Window bookkeeping: a clear restarts the window, optionally seeded by this cycle's sample.
    always_comb begin
        w_count_next = r_count;
        w_acc_next   = r_acc;
        if (clear) begin
            w_count_next = in_valid ? CNT_W'(1) : '0;
            w_acc_next   = in_valid ? ACC_W'(data_in) : '0;
        end else if (in_valid) begin
            w_count_next = (r_count == CNT_FULL) ? CNT_FULL : r_count + CNT_W'(1);
            w_acc_next   = r_acc + ACC_W'(data_in) - ACC_W'(r_taps[WINDOW-1]);
        end else begin
            w_count_next = r_count;
            w_acc_next   = r_acc;
        end
        w_s1_valid = in_valid && ((w_mode == MODE_BYP) || (w_count_next == CNT_FULL));
    end

    // Tap delay line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WINDOW; i++) r_taps[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < WINDOW; i++) r_taps[i] <= '0;
            if (in_valid) r_taps[0] <= data_in;
        end else if (in_valid) begin
            r_taps[0] <= data_in;
            for (int i = 1; i < WINDOW; i++) r_taps[i] <= r_taps[i-1];
        end
    end

    // Stage 1: accumulator, fill counter and the sample's centre tap, raw value and mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc      <= '0;
            r_count    <= '0;
            r_primed   <= 1'b0;
            r_s1_valid <= 1'b0;
            r_s1_ctr   <= '0;
            r_s1_raw   <= '0;
            r_s1_mode  <= MODE_SEP;
        end else begin
            r_acc      <= w_acc_next;
            r_count    <= w_count_next;
            r_primed   <= (w_count_next == CNT_FULL);
            r_s1_valid <= w_s1_valid;
            if (in_valid) begin
                // Post-shift centre tap is the current tap just below it.
                r_s1_ctr  <= clear ? '0 : r_taps[CTR-1];
                r_s1_raw  <= data_in;
                r_s1_mode <= w_mode;
            end
        end
    end

    // Stage 2 arithmetic: reciprocal multiply with round-half-up, then saturating residual.
    always_comb begin
        w_round       = PROD_W'(r_acc) * RECIP + HALF;
        w_luma_wide   = w_round >>> FRAC_W;
        w_luma_sat    = sat_luma(w_luma_wide);
        w_chroma_wide = {r_s1_ctr[DATA_W-1], r_s1_ctr} - {w_luma_sat[DATA_W-1], w_luma_sat};
        w_chroma_sat  = sat_chroma(w_chroma_wide);
        w_luma_sel    = w_luma_sat;
        w_chroma_sel  = w_chroma_sat;
        case (r_s1_mode)
            MODE_BYP: begin
                w_luma_sel   = r_s1_raw;
                w_chroma_sel = '0;
            end
            MODE_LUMA: begin
                w_luma_sel   = w_luma_sat;
                w_chroma_sel = '0;
            end
            default: begin
                w_luma_sel   = w_luma_sat;
                w_chroma_sel = w_chroma_sat;
            end
        endcase
    end

    // Output register; a clear kills the sample in stage 1 while data outputs hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_luma      <= '0;
            r_chroma    <= '0;
        end else begin
            r_out_valid <= r_s1_valid && !clear;
            if (r_s1_valid && !clear) begin
                r_luma   <= w_luma_sel;
                r_chroma <= w_chroma_sel;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign luma_out   = r_luma;
    assign chroma_out = r_chroma;
    assign primed     = r_primed;

endmodule
